seg_scroll_ctrl: RTL and testbench

Sequencer that scrolls a short programmable digit message across the four active-low seven-segment displays (ss3 leftmost to ss0 rightmost). A host loads message entries through a simple write port, then starts a run. The block owns the step-rate prescaler, the window position, the run/pause/stop state machine and the digit-to-segment decode. It replaces hard-coded per-state display patterns with a data-driven scheduler.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_hex_decoder.sv | 11 +
 rtl/seg_scroll_ctrl.sv | 118 +++++++++++
 tb/tb_seg_scroll_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared codes, segment patterns and controller states for the digit scroller
//   SEG_BLANK  - all segments off (active-low)
//   CODE_BLANK - message code that renders as blank
//   SEG_0..F   - active-low {g,f,e,d,c,b,a} patterns for hex digits
//   SEG_LUT    - digit patterns indexed by hex value
//   state_t    - IDLE / RUN / PAUSE
package seg_pkg;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [4:0] CODE_BLANK = 5'h10;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [15:0][6:0] SEG_LUT = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                          SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: 5-bit message code to active-low seven-segment pattern
//   i_code - bit4 set means blank, otherwise bits3:0 are a hex digit
//   o_seg  - active-low {g,f,e,d,c,b,a}
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_seg
);
  assign o_seg = i_code[4] ? SEG_BLANK : SEG_LUT[i_code[3:0]];
endmodule

// File: rtl/seg_scroll_ctrl.sv
// seg_scroll_ctrl: scrolls a programmable digit message across four seven-segment displays
//   clk, rst            - clock, asynchronous active-high reset
//   wr_en/addr/data     - message buffer write port, honoured only while idle
//   msg_len, loop       - run length (1..8) and repeat flag, latched on accepted start
//   start, stop, pause  - run control
//   busy, done, pos     - run status, end-of-run pulse, window start index
//   ss3..ss0            - registered active-low segments, ss3 leftmost
module seg_scroll_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MSG_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic [3:0] msg_len,
  input  logic       loop,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  output logic       busy,
  output logic       done,
  output logic [2:0] pos,
  output logic [6:0] ss3,
  output logic [6:0] ss2,
  output logic [6:0] ss1,
  output logic [6:0] ss0
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  state_t r_state, w_nxt_state;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic [2:0] r_pos, w_nxt_pos;
  logic [3:0] r_len, w_nxt_len;
  logic r_loop, r_done, w_done_nxt;
  logic [4:0] r_buf [MSG_DEPTH];
  logic [4:0] w_buf [MSG_DEPTH];
  logic [3:0][6:0] r_ss, w_seg;
  logic [3:0][4:0] w_code;
  logic [3:0][3:0] w_idx;
  logic w_busy, w_start_ok, w_tc, w_last;
  assign w_busy     = r_state != IDLE;
  assign w_start_ok = !w_busy && start && msg_len != 4'd0 && msg_len <= 4'd8;
  assign w_tc       = r_cnt == CNT_LAST;
  assign w_last     = {1'b0, r_pos} == r_len - 4'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_nxt_state;
  // A terminal count steps even while pause is high, so PAUSE never holds a terminal count.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pos   = r_pos;
    w_nxt_cnt   = r_cnt;
    if (!w_busy) begin
      if (w_start_ok) begin
        w_nxt_state = RUN;
        w_nxt_pos   = '0;
        w_nxt_cnt   = '0;
      end
    end else if (stop) begin
      w_nxt_state = IDLE;
      w_nxt_pos   = '0;
      w_nxt_cnt   = '0;
    end else if (w_tc) begin
      w_nxt_cnt   = '0;
      w_nxt_state = pause ? PAUSE : RUN;
      w_nxt_pos   = w_last ? 3'd0 : r_pos + 3'd1;
      if (w_last && !r_loop) w_nxt_state = IDLE;
    end else begin
      w_nxt_state = pause ? PAUSE : RUN;
      w_nxt_cnt   = pause ? r_cnt : r_cnt + CW'(1);
    end
  end
  // Window codes are built from next-cycle state and buffer so the segment registers
  // already hold the new window on the cycle the state changes.
  always_comb begin
    w_buf = r_buf;
    if (!w_busy && wr_en) w_buf[wr_addr] = wr_data;
    w_nxt_len  = w_start_ok ? msg_len : r_len;
    w_done_nxt = w_busy && !stop && w_tc && w_last && !r_loop;
    for (int k = 0; k < 4; k++) begin
      w_idx[k]  = {1'b0, w_nxt_pos} + 4'(3 - k);
      w_code[k] = (w_nxt_state == IDLE || w_idx[k] >= w_nxt_len) ? CODE_BLANK : w_buf[w_idx[k][2:0]];
    end
  end
  for (genvar k = 0; k < 4; k++) begin : g_dec
    seg_hex_decoder u_dec (.i_code(w_code[k]), .o_seg(w_seg[k]));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pos  <= '0;
      r_len  <= '0;
      r_loop <= 1'b0;
      r_done <= 1'b0;
      r_ss   <= {4{SEG_BLANK}};
      for (int i = 0; i < MSG_DEPTH; i++) r_buf[i] <= CODE_BLANK;
    end else begin
      r_cnt  <= w_nxt_cnt;
      r_pos  <= w_nxt_pos;
      r_len  <= w_nxt_len;
      r_loop <= w_start_ok ? loop : r_loop;
      r_done <= w_done_nxt;
      r_ss   <= w_seg;
      r_buf  <= w_buf;
    end
  end
  assign busy = w_busy;
  assign done = r_done;
  assign pos  = r_pos;
  assign ss3  = r_ss[3];
  assign ss2  = r_ss[2];
  assign ss1  = r_ss[1];
  assign ss0  = r_ss[0];
endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// tb_seg_scroll_ctrl: scoreboard bench with a message-level reference model
module tb_seg_scroll_ctrl;
  localparam int TD = 4;
  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] DEC [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  typedef struct packed {
    logic busy;
    logic done;
    logic [2:0] pos;
    logic [27:0] ss;
  } exp_t;
  logic clk = 0, rst = 0, wr_en = 0, loop = 0, start = 0, stop = 0, pause = 0;
  logic [2:0] wr_addr = 0;
  logic [4:0] wr_data = 0;
  logic [3:0] msg_len = 0;
  logic busy, done;
  logic [2:0] pos;
  logic [6:0] ss3, ss2, ss1, ss0;
  int checks = 0, errors = 0;
  exp_t q[$];
  exp_t mon_e, mon_g;
  bit m_busy, m_done, m_loop;
  int m_pos, m_ticks, m_len;
  int m_buf [8];

  seg_scroll_ctrl #(.TICK_DIV(TD), .MSG_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .loop(loop), .start(start), .stop(stop), .pause(pause),
    .busy(busy), .done(done), .pos(pos), .ss3(ss3), .ss2(ss2), .ss1(ss1), .ss0(ss0)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(int c);
    return c >= 16 ? BLK : DEC[c];
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.busy = m_busy;
    e.done = m_done;
    e.pos  = 3'(m_pos);
    for (int j = 0; j < 4; j++)
      if (m_busy && m_pos + j < m_len) e.ss[27-7*j -: 7] = dec(m_buf[m_pos+j]);
      else e.ss[27-7*j -: 7] = BLK;
    return e;
  endfunction

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, g, x);
    end
  endtask

  // One clock: the model advances with the inputs now on the pins; its view of the
  // next edge's outputs is queued for the monitor.
  task automatic step();
    if (rst) begin
      m_busy = 0; m_done = 0; m_pos = 0; m_ticks = 0;
      foreach (m_buf[i]) m_buf[i] = 16;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (wr_en) m_buf[wr_addr] = int'(wr_data);
        if (start && msg_len >= 1 && msg_len <= 8) begin
          m_busy = 1; m_pos = 0; m_ticks = 0; m_len = int'(msg_len); m_loop = loop;
        end
      end else if (stop) begin
        m_busy = 0; m_pos = 0;
      end else if (!pause || m_ticks == TD - 1) begin
        m_ticks++;
        if (m_ticks == TD) begin
          m_ticks = 0;
          if (m_pos < m_len - 1) m_pos++;
          else if (m_loop) m_pos = 0;
          else begin m_busy = 0; m_done = 1; m_pos = 0; end
        end
      end
    end
    q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1; wr_addr = 3'(a); wr_data = 5'(d);
    step();
    wr_en = 0;
  endtask

  task automatic go(input int len, input bit lp);
    start = 1; msg_len = 4'(len); loop = lp;
    step();
    start = 0;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_g = {busy, done, pos, ss3, ss2, ss1, ss0};
      checks++;
      if (mon_g !== mon_e) begin
        errors++;
        $display("FAIL cycle t=%0t got busy=%b done=%b pos=%0d ss=%028b expected busy=%b done=%b pos=%0d ss=%028b",
                 $time, mon_g.busy, mon_g.done, mon_g.pos, mon_g.ss, mon_e.busy, mon_e.done, mon_e.pos, mon_e.ss);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    int dn;
    #1 rst = 1;
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_pos", 32'(pos), 0);
    chk("reset_ss", 32'({ss3, ss2, ss1, ss0}), 32'({4{BLK}}));
    @(negedge clk);
    step();
    rst = 0;
    wr(0, 5); wr(1, 0); wr(2, 7); wr(3, 2);
    go(4, 0);
    chk("win0_ss", 32'({ss3, ss2, ss1, ss0}), 32'({7'b0010010, 7'b1000000, 7'b1111000, 7'b0100100}));
    chk("win0_busy", 32'(busy), 1);
    chk("win0_pos", 32'(pos), 0);
    run(4);
    chk("win1_pos", 32'(pos), 1);
    chk("win1_ss", 32'({ss3, ss2, ss1, ss0}), 32'({7'b1000000, 7'b1111000, 7'b0100100, BLK}));
    dn = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      dn += int'(done);
    end
    chk("done_pulses", 32'(dn), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_ss", 32'({ss3, ss2, ss1, ss0}), 32'({4{BLK}}));
    wr(0, 10); wr(1, 11);
    go(2, 1);
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      chk("loop_pos", 32'(pos), 32'(k % 2));
      for (int c = 0; c < 4; c++) begin
        step();
        dn += int'(done);
      end
    end
    chk("loop_no_done", 32'(dn), 0);
    stop = 1; step(); stop = 0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_ss", 32'({ss3, ss2, ss1, ss0}), 32'({4{BLK}}));
    go(4, 0);
    run(2);
    pause = 1; run(10);
    chk("pause_pos", 32'(pos), 0);
    chk("pause_ss", 32'({ss3, ss2, ss1, ss0}), 32'({7'b0001000, 7'b0000011, 7'b1111000, 7'b0100100}));
    pause = 0; run(1);
    chk("resume_hold", 32'(pos), 0);
    run(1);
    chk("resume_step", 32'(pos), 1);
    stop = 1; step(); stop = 0;
    go(1, 0);
    run(3);
    stop = 1; step(); stop = 0;
    chk("stop_tc_done", 32'(done), 0);
    chk("stop_tc_busy", 32'(busy), 0);
    run(1);
    go(0, 0);
    chk("len0_busy", 32'(busy), 0);
    go(9, 0);
    chk("len9_busy", 32'(busy), 0);
    go(4, 0);
    wr(0, 3);
    run(20);
    go(4, 0);
    chk("busy_write_ignored", 32'(ss3), 32'(7'b0001000));
    stop = 1; step(); stop = 0;
    go(4, 1);
    run(5);
    #3 rst = 1;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_ss", 32'({ss3, ss2, ss1, ss0}), 32'({4{BLK}}));
    chk("async_pos", 32'(pos), 0);
    step();
    rst = 0;
    go(8, 0);
    chk("buf_cleared", 32'({ss3, ss2, ss1, ss0}), 32'({4{BLK}}));
    stop = 1; step(); stop = 0;
    for (int k = 0; k < 800; k++) begin
      wr_en   = $urandom_range(0, 3) == 0;
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 5'($urandom_range(0, 31));
      start   = $urandom_range(0, 7) == 0;
      msg_len = 4'($urandom_range(0, 9));
      loop    = 1'($urandom_range(0, 1));
      stop    = $urandom_range(0, 31) == 0;
      pause   = $urandom_range(0, 4) == 0;
      rst     = $urandom_range(0, 199) == 0;
      step();
    end
    {wr_en, start, stop, pause, rst} = '0;
    run(2);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
